// File: rtl/solver_pkg.sv
// Shared encodings for the solver front end: config selectors,
// solver write-port selectors and the point loader state machine.
package solver_pkg;

  localparam logic [1:0] CFG_ORIGIN_RE = 2'd0;
  localparam logic [1:0] CFG_ORIGIN_IM = 2'd1;
  localparam logic [1:0] CFG_STEP_RE   = 2'd2;
  localparam logic [1:0] CFG_STEP_IM   = 2'd3;

  localparam logic WR_SEL_RE = 1'b0;
  localparam logic WR_SEL_IM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT,
    ST_WR_RE,
    ST_WR_IM,
    ST_GO,
    ST_STEP,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/limb_serial_adder.sv
// One limb of a multi-limb two's-complement add per cycle. The carry is
// held in a register between limbs; 'clear' forces a zero carry-in so the
// first (least-significant) limb of each add starts fresh.
module limb_serial_adder #(
  parameter int LIMB_SIZE_BITS = 27
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [LIMB_SIZE_BITS-1:0] a,
  input  logic [LIMB_SIZE_BITS-1:0] b,
  output logic [LIMB_SIZE_BITS-1:0] sum
);

  logic                    carry_q;
  logic                    carry_in;
  logic [LIMB_SIZE_BITS:0] full_sum;

  assign carry_in = clear ? 1'b0 : carry_q;
  assign full_sum = {1'b0, a} + {1'b0, b} + {{LIMB_SIZE_BITS{1'b0}}, carry_in};
  assign sum      = full_sum[LIMB_SIZE_BITS-1:0];

  // Carry register: captures the carry out of the limb just added.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) carry_q <= 1'b0;
    else if (enable) carry_q <= full_sum[LIMB_SIZE_BITS];
  end

endmodule

// File: rtl/point_loader.sv
// Walks a width x height pixel grid in raster order, streaming c_re and
// c_im limb-by-limb into the solver and launching it once per pixel.
// Successive c values are produced by a shared limb-serial adder.
module point_loader
  import solver_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 27,
  parameter int NUM_LIMBS       = 4,
  parameter int COORD_BITS      = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cfg_wr_en,
  input  logic [1:0]                 cfg_sel,
  input  logic [LIMB_INDEX_BITS-1:0] cfg_limb,
  input  logic [LIMB_SIZE_BITS-1:0]  cfg_data,
  input  logic [COORD_BITS-1:0]      width,
  input  logic [COORD_BITS-1:0]      height,
  input  logic                       start,
  output logic                       busy,
  input  logic                       sol_ready,
  output logic                       wr_en,
  output logic                       wr_sel,
  output logic [LIMB_INDEX_BITS-1:0] wr_limb,
  output logic [LIMB_SIZE_BITS-1:0]  wr_data,
  output logic                       sol_go,
  output logic [COORD_BITS-1:0]      pix_x,
  output logic [COORD_BITS-1:0]      pix_y,
  output logic                       frame_done
);

  localparam int IW = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [LIMB_INDEX_BITS-1:0] LAST_LIMB = LIMB_INDEX_BITS'(NUM_LIMBS - 1);

  loader_state_t state, next_state;

  logic [LIMB_SIZE_BITS-1:0] origin_re [NUM_LIMBS];
  logic [LIMB_SIZE_BITS-1:0] origin_im [NUM_LIMBS];
  logic [LIMB_SIZE_BITS-1:0] step_re   [NUM_LIMBS];
  logic [LIMB_SIZE_BITS-1:0] step_im   [NUM_LIMBS];
  logic [LIMB_SIZE_BITS-1:0] cur_re    [NUM_LIMBS];
  logic [LIMB_SIZE_BITS-1:0] cur_im    [NUM_LIMBS];

  logic [COORD_BITS-1:0]      width_q, height_q, x, y;
  logic [LIMB_INDEX_BITS-1:0] limb_cnt, add_cnt;
  logic [IW-1:0]              wr_idx, add_idx;
  logic                       row_end, last_row, limb_last, add_last, cfg_ok;
  logic [LIMB_SIZE_BITS-1:0]  add_a, add_b, add_sum;

  assign wr_idx    = limb_cnt[IW-1:0];
  assign add_idx   = IW'(NUM_LIMBS - 1) - add_cnt[IW-1:0];
  assign row_end   = (x == width_q - COORD_BITS'(1));
  assign last_row  = (y == height_q - COORD_BITS'(1));
  assign limb_last = (limb_cnt == LAST_LIMB);
  assign add_last  = (add_cnt == LAST_LIMB);
  assign cfg_ok    = cfg_wr_en && (state == ST_IDLE) && (int'(cfg_limb) < NUM_LIMBS);

  // At a row end the add advances c_im; otherwise it advances c_re.
  assign add_a = row_end ? cur_im[add_idx]  : cur_re[add_idx];
  assign add_b = row_end ? step_im[add_idx] : step_re[add_idx];

  limb_serial_adder #(.LIMB_SIZE_BITS(LIMB_SIZE_BITS)) u_adder (
    .clock  (clock),
    .reset  (reset),
    .clear  (add_cnt == '0),
    .enable (state == ST_STEP),
    .a      (add_a),
    .b      (add_b),
    .sum    (add_sum)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; an empty frame is detected on the latched size in INIT.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_INIT;
      ST_INIT:  next_state = (width_q == '0 || height_q == '0) ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (sol_ready) next_state = ST_WR_RE;
      ST_WR_RE: if (limb_last) next_state = ST_WR_IM;
      ST_WR_IM: if (limb_last) next_state = ST_GO;
      ST_GO:    next_state = (row_end && last_row) ? ST_DONE : ST_STEP;
      ST_STEP:  if (add_last) next_state = ST_WAIT;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so a reset clears them immediately.
  always_comb begin
    busy       = (state != ST_IDLE) && (state != ST_DONE);
    wr_en      = (state == ST_WR_RE) || (state == ST_WR_IM);
    wr_sel     = (state == ST_WR_IM) ? WR_SEL_IM : WR_SEL_RE;
    wr_limb    = wr_en ? limb_cnt : '0;
    wr_data    = '0;
    if (state == ST_WR_RE) wr_data = cur_re[wr_idx];
    if (state == ST_WR_IM) wr_data = cur_im[wr_idx];
    sol_go     = (state == ST_GO);
    frame_done = (state == ST_DONE);
  end

  // Config limb storage, writable only while idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LIMBS; i++) begin
        origin_re[i] <= '0;
        origin_im[i] <= '0;
        step_re[i]   <= '0;
        step_im[i]   <= '0;
      end
    end else if (cfg_ok) begin
      case (cfg_sel)
        CFG_ORIGIN_RE: origin_re[cfg_limb[IW-1:0]] <= cfg_data;
        CFG_ORIGIN_IM: origin_im[cfg_limb[IW-1:0]] <= cfg_data;
        CFG_STEP_RE:   step_re[cfg_limb[IW-1:0]]   <= cfg_data;
        default:       step_im[cfg_limb[IW-1:0]]   <= cfg_data;
      endcase
    end
  end

  // Frame walk: coordinates, current c values, limb counters and pixel tags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LIMBS; i++) begin
        cur_re[i] <= '0;
        cur_im[i] <= '0;
      end
      width_q  <= '0;
      height_q <= '0;
      x        <= '0;
      y        <= '0;
      limb_cnt <= '0;
      add_cnt  <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            width_q  <= width;
            height_q <= height;
          end
        end
        ST_INIT: begin
          cur_re   <= origin_re;
          cur_im   <= origin_im;
          x        <= '0;
          y        <= '0;
          limb_cnt <= '0;
          add_cnt  <= '0;
        end
        ST_WR_RE, ST_WR_IM: begin
          limb_cnt <= limb_last ? '0 : limb_cnt + 1'b1;
          if (state == ST_WR_IM && limb_last) begin
            pix_x <= x;
            pix_y <= y;
          end
        end
        ST_STEP: begin
          if (row_end) begin
            cur_im[add_idx] <= add_sum;
            if (add_cnt == '0) cur_re <= origin_re;
          end else begin
            cur_re[add_idx] <= add_sum;
          end
          add_cnt <= add_last ? '0 : add_cnt + 1'b1;
          if (add_last) begin
            if (row_end) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_point_loader.sv
// Directed bench for point_loader with 2 limbs of 8 bits each.
module tb_point_loader;

  localparam int LIB = 6;
  localparam int LSB = 8;
  localparam int NL  = 2;
  localparam int CB  = 10;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_wr_en = 1'b0;
  logic [1:0]     cfg_sel = '0;
  logic [LIB-1:0] cfg_limb = '0;
  logic [LSB-1:0] cfg_data = '0;
  logic [CB-1:0]  width = '0;
  logic [CB-1:0]  height = '0;
  logic           start = 1'b0;
  logic           busy;
  logic           sol_ready = 1'b1;
  logic           wr_en;
  logic           wr_sel;
  logic [LIB-1:0] wr_limb;
  logic [LSB-1:0] wr_data;
  logic           sol_go;
  logic [CB-1:0]  pix_x;
  logic [CB-1:0]  pix_y;
  logic           frame_done;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  point_loader #(
    .LIMB_INDEX_BITS(LIB),
    .LIMB_SIZE_BITS (LSB),
    .NUM_LIMBS      (NL),
    .COORD_BITS     (CB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_sel    (cfg_sel),
    .cfg_limb   (cfg_limb),
    .cfg_data   (cfg_data),
    .width      (width),
    .height     (height),
    .start      (start),
    .busy       (busy),
    .sol_ready  (sol_ready),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_limb    (wr_limb),
    .wr_data    (wr_data),
    .sol_go     (sol_go),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_done (frame_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [LIB-1:0] limb,
                               input logic [LSB-1:0] data);
    cfg_wr_en = 1'b1;
    cfg_sel   = sel;
    cfg_limb  = limb;
    cfg_data  = data;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  // Values are written as {limb0, limb1}; limb 0 is most significant.
  task automatic loadValue(input logic [1:0] sel, input logic [15:0] value);
    applyStimulus(sel, 6'd0, value[15:8]);
    applyStimulus(sel, 6'd1, value[7:0]);
  endtask

  task automatic startFrame(input logic [CB-1:0] w, input logic [CB-1:0] h);
    width  = w;
    height = h;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic waitWrEn();
    int n = 0;
    while (!wr_en && n < 64) begin
      tick();
      n++;
    end
    if (!wr_en) checkOutput("wr_en_timeout", 32'(wr_en), 32'd1);
  endtask

  function automatic logic [7:0] limbOf(input logic [15:0] value, input int i);
    return (i == 0) ? value[15:8] : value[7:0];
  endfunction

  // Expects one full point: re limbs, im limbs, then the launch cycle.
  task automatic checkPoint(input logic [15:0] expRe, input logic [15:0] expIm,
                            input int px, input int py);
    waitWrEn();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NL; i++) begin
        checkOutput("wr_en",   32'(wr_en), 32'd1);
        checkOutput("wr_sel",  32'(wr_sel), 32'(s));
        checkOutput("wr_limb", 32'(wr_limb), 32'(i));
        checkOutput("wr_data", 32'(wr_data),
                    32'(limbOf((s == 0) ? expRe : expIm, i)));
        checkOutput("go_during_write", 32'(sol_go), 32'd0);
        tick();
      end
    end
    checkOutput("sol_go", 32'(sol_go), 32'd1);
    checkOutput("go_wr_en", 32'(wr_en), 32'd0);
    checkOutput("pix_x", 32'(pix_x), 32'(px));
    checkOutput("pix_y", 32'(pix_y), 32'(py));
    tick();
  endtask

  task automatic checkDone();
    checkOutput("frame_done", 32'(frame_done), 32'd1);
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("done_go", 32'(sol_go), 32'd0);
    tick();
    checkOutput("frame_done_pulse", 32'(frame_done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_go", 32'(sol_go), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_pix_x", 32'(pix_x), 32'd0);
    reset = 1'b1;
    tick();

    // Basic frame with carry across limbs
    $display("[TB] basic frame");
    loadValue(2'd0, 16'h01F0);
    loadValue(2'd2, 16'h0020);
    startFrame(10'd2, 10'd1);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkPoint(16'h01F0, 16'h0000, 0, 0);
    checkPoint(16'h0210, 16'h0000, 1, 0);
    checkDone();

    // Negative wrap; an out-of-range limb write must not alias limb 0
    $display("[TB] negative wrap");
    loadValue(2'd0, 16'hFFFF);
    loadValue(2'd2, 16'h0001);
    applyStimulus(2'd0, 6'd2, 8'h77);
    startFrame(10'd2, 10'd1);
    checkPoint(16'hFFFF, 16'h0000, 0, 0);
    checkPoint(16'h0000, 16'h0000, 1, 0);
    checkDone();

    // Row wrap; a config write while busy is ignored
    $display("[TB] row wrap");
    loadValue(2'd0, 16'h0100);
    loadValue(2'd2, 16'h0080);
    loadValue(2'd1, 16'h0000);
    loadValue(2'd3, 16'h0040);
    startFrame(10'd2, 10'd2);
    applyStimulus(2'd0, 6'd0, 8'hAA);
    checkPoint(16'h0100, 16'h0000, 0, 0);
    checkPoint(16'h0180, 16'h0000, 1, 0);
    checkPoint(16'h0100, 16'h0040, 0, 1);
    checkPoint(16'h0180, 16'h0040, 1, 1);
    checkDone();

    // Backpressure after the first point
    $display("[TB] backpressure");
    loadValue(2'd0, 16'h0010);
    loadValue(2'd2, 16'h0001);
    startFrame(10'd2, 10'd1);
    checkPoint(16'h0010, 16'h0000, 0, 0);
    sol_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checkOutput("stall_wr_en", 32'(wr_en), 32'd0);
      tick();
    end
    sol_ready = 1'b1;
    tick();
    checkOutput("resume_wr_en", 32'(wr_en), 32'd1);
    checkPoint(16'h0011, 16'h0000, 1, 0);
    checkDone();

    // Zero-size frame
    $display("[TB] zero-size frame");
    startFrame(10'd0, 10'd3);
    checkOutput("zero_init_done", 32'(frame_done), 32'd0);
    checkOutput("zero_init_wr", 32'(wr_en), 32'd0);
    checkOutput("zero_init_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("zero_wr_en", 32'(wr_en), 32'd0);
    checkDone();

    // Reset in the middle of the imaginary write
    $display("[TB] reset mid-write");
    loadValue(2'd0, 16'h1234);
    loadValue(2'd1, 16'h5678);
    startFrame(10'd1, 10'd1);
    waitWrEn();
    tick();
    tick();
    tick();
    checkOutput("mid_wr_sel", 32'(wr_sel), 32'd1);
    checkOutput("mid_wr_data", 32'(wr_data), 32'h78);
    reset = 1'b0;
    #1;
    checkOutput("abort_wr_en", 32'(wr_en), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_go", 32'(sol_go), 32'd0);
    checkOutput("abort_wr_data", 32'(wr_data), 32'd0);
    checkOutput("abort_pix_x", 32'(pix_x), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("held_go", 32'(sol_go), 32'd0);
    end
    reset = 1'b1;
    tick();
    loadValue(2'd0, 16'h00AB);
    startFrame(10'd1, 10'd1);
    checkPoint(16'h00AB, 16'h0000, 0, 0);
    checkDone();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
